// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream from the host bridge into the program loader
//
// Signals:
//   byte_in     configuration byte offered by the host
//   byte_valid  byte_in holds a byte to transfer
//   byte_ready  loader accepts the byte on this edge
// Modports: master = host side, slave = loader side.
interface prog_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serialises host bytes into the controller's instruction memory
//
// Ports:
//   clock, rst_n   system clock, synchronous active-low reset
//   start          begin a load (only looked at while idle)
//   abort          cancel a load in progress; overrides everything else
//   bus            byte stream (slave side): byte_in / byte_valid / byte_ready
//   prog_enable    holds the controller in programming mode
//   prog_advance   sink shifts prog_data in on this cycle
//   prog_data      serial program bit, LSB of each byte first
//   busy           loader is not idle
//   done           one-cycle pulse after a complete image has been shifted
//   checksum       XOR of every byte accepted in the current/last load
//   bits_sent      bits shifted so far in the current/last load
module prog_loader #(
    parameter int TOTAL_BITS = 256,
    parameter int CNT_WIDTH  = $clog2(TOTAL_BITS + 1)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    prog_loader_if.slave         bus,
    output logic                 prog_enable,
    output logic                 prog_advance,
    output logic                 prog_data,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           checksum,
    output logic [CNT_WIDTH-1:0] bits_sent
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        FINISH
    } state_t;

    // Count value just before the final bit goes out.
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(TOTAL_BITS - 1);

    state_t     state;
    state_t     state_next;
    logic       done_next;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       last_bit;

    assign last_bit = (bits_sent == LAST_BIT);

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                // byte_ready is high throughout this state, so valid alone is the handshake.
                if (abort) begin
                    state_next = IDLE;
                end else if (bus.byte_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Image length is checked before byte boundary so a partial last byte ends early.
                if (abort) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = FINISH;
                end else if (bit_idx == 3'd7) begin
                    state_next = WAIT_BYTE;
                end
            end
            FINISH: begin
                state_next = IDLE;
                done_next  = !abort;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Datapath: abort freezes checksum/bits_sent so the host can inspect how far the load got.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            shreg     <= 8'd0;
            bit_idx   <= 3'd0;
            checksum  <= 8'd0;
            bits_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        checksum  <= 8'd0;
                        bits_sent <= '0;
                        bit_idx   <= 3'd0;
                    end
                end
                WAIT_BYTE: begin
                    if (!abort && bus.byte_valid) begin
                        shreg    <= bus.byte_in;
                        checksum <= checksum ^ bus.byte_in;
                        bit_idx  <= 3'd0;
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        shreg     <= {1'b0, shreg[7:1]};
                        bits_sent <= bits_sent + 1'b1;
                        bit_idx   <= bit_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.byte_ready = (state == WAIT_BYTE);
    assign prog_enable    = (state != IDLE);
    assign busy           = (state != IDLE);
    assign prog_advance   = (state == SHIFT);
    assign prog_data      = (state == SHIFT) && shreg[0];

endmodule
